// File: rtl/reg_file_2w2r_scoreboard.sv
// rtl/reg_file_2w2r_scoreboard.sv - two-write, two-read register file with bypass and load busy scoreboard
module reg_file_2w2r_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1,
    input  logic [ADDR_WIDTH-1:0] rd_addr_2,
    output logic [DATA_WIDTH-1:0] rd_data_1,
    output logic [DATA_WIDTH-1:0] rd_data_2,
    output logic                  rd_busy_1,
    output logic                  rd_busy_2,
    input  logic                  wr_en_a,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    input  logic                  wr_en_b,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    input  logic                  busy_set,
    input  logic [ADDR_WIDTH-1:0] busy_addr
);

    localparam int  DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit  HAS_ZERO  = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;

    logic [DEPTH-1:0]      sel_a;
    logic [DEPTH-1:0]      sel_b;
    logic [DEPTH-1:0]      set_v;
    logic [DEPTH-1:0]      clr_v;

    // Port B write and port A write to the same address: B (load) wins.
    // The hardwired zero register simply never gets a select.
    function automatic logic [DATA_WIDTH-1:0] resolve_read(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  live,
        input logic                  en_a,
        input logic [ADDR_WIDTH-1:0] addr_a,
        input logic [DATA_WIDTH-1:0] data_a,
        input logic                  en_b,
        input logic [ADDR_WIDTH-1:0] addr_b,
        input logic [DATA_WIDTH-1:0] data_b,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] result;
        result = stored;
        if (!live) begin
            result = '0;
        end else if (HAS_ZERO && addr == '0) begin
            result = '0;
        end else if (en_b && addr_b == addr) begin
            result = data_b;
        end else if (en_a && addr_a == addr) begin
            result = data_a;
        end
        return result;
    endfunction

    // A busy bit is hidden as soon as its clearing writeback is on port B,
    // so the consumer sees "not busy" in the same cycle as the bypassed data.
    function automatic logic resolve_busy(
        input logic                  addr_busy,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  live,
        input logic                  en_b,
        input logic [ADDR_WIDTH-1:0] addr_b
    );
        logic result;
        result = live && addr_busy && !(en_b && addr_b == addr);
        if (HAS_ZERO && addr == '0) begin
            result = 1'b0;
        end
        return result;
    endfunction

    // Decode per-register write selects and scoreboard set/clear strobes.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        set_v = '0;
        clr_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(HAS_ZERO && i == 0)) begin
                sel_a[i] = wr_en_a  && (wr_addr_a == ADDR_WIDTH'(i));
                sel_b[i] = wr_en_b  && (wr_addr_b == ADDR_WIDTH'(i));
                set_v[i] = busy_set && (busy_addr == ADDR_WIDTH'(i));
                clr_v[i] = wr_en_b  && (wr_addr_b == ADDR_WIDTH'(i));
            end
        end
    end

    // Register storage and scoreboard; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel_b[i]) begin
                    regs_q[i] <= wr_data_b;
                end else if (sel_a[i]) begin
                    regs_q[i] <= wr_data_a;
                end
                // A new load issued in the same edge as the old one's
                // writeback keeps the register busy.
                if (set_v[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (clr_v[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Read port 1: zero register, then B bypass, A bypass, stored value.
    always_comb begin
        rd_data_1 = resolve_read(rd_addr_1, rst_n, wr_en_a, wr_addr_a, wr_data_a,
                                 wr_en_b, wr_addr_b, wr_data_b, regs_q[rd_addr_1]);
        rd_busy_1 = resolve_busy(busy_q[rd_addr_1], rd_addr_1, rst_n, wr_en_b, wr_addr_b);
    end

    // Read port 2: resolved independently of port 1.
    always_comb begin
        rd_data_2 = resolve_read(rd_addr_2, rst_n, wr_en_a, wr_addr_a, wr_data_a,
                                 wr_en_b, wr_addr_b, wr_data_b, regs_q[rd_addr_2]);
        rd_busy_2 = resolve_busy(busy_q[rd_addr_2], rd_addr_2, rst_n, wr_en_b, wr_addr_b);
    end

endmodule

// File: tb/tb_reg_file_2w2r_scoreboard.sv
// tb/tb_reg_file_2w2r_scoreboard.sv - self-checking bench for reg_file_2w2r_scoreboard
module tb_reg_file_2w2r_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr_1;
    logic [4:0]  rd_addr_2;
    logic [31:0] rd_data_1;
    logic [31:0] rd_data_2;
    logic        rd_busy_1;
    logic        rd_busy_2;
    logic        wr_en_a;
    logic [4:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic        wr_en_b;
    logic [4:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic        busy_set;
    logic [4:0]  busy_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    reg_file_2w2r_scoreboard #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rd_addr_1(rd_addr_1),
        .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1),
        .rd_data_2(rd_data_2),
        .rd_busy_1(rd_busy_1),
        .rd_busy_2(rd_busy_2),
        .wr_en_a(wr_en_a),
        .wr_addr_a(wr_addr_a),
        .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b),
        .wr_addr_b(wr_addr_b),
        .wr_data_b(wr_data_b),
        .busy_set(busy_set),
        .busy_addr(busy_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: reset empties everything, B overrides A, a new
    // load overrides the writeback's clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  <= 32'h0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (wr_en_a) m_reg[wr_addr_a] <= wr_data_a;
            if (wr_en_b) m_reg[wr_addr_b] <= wr_data_b;
            if (wr_en_b) m_busy[wr_addr_b] <= 1'b0;
            if (busy_set) m_busy[busy_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] addr);
        if (!rst_n || addr == 5'd0) return 32'h0;
        if (wr_en_b && wr_addr_b == addr) return wr_data_b;
        if (wr_en_a && wr_addr_a == addr) return wr_data_a;
        return m_reg[addr];
    endfunction

    function automatic logic exp_busy(input logic [4:0] addr);
        if (!rst_n || addr == 5'd0) return 1'b0;
        return m_busy[addr] && !(wr_en_b && wr_addr_b == addr);
    endfunction

    // Compare every cycle on the falling edge against the model.
    always @(negedge clk) begin
        check("cmp_rd_data_1", rd_data_1, exp_data(rd_addr_1));
        check("cmp_rd_data_2", rd_data_2, exp_data(rd_addr_2));
        check("cmp_rd_busy_1", {31'h0, rd_busy_1}, {31'h0, exp_busy(rd_addr_1)});
        check("cmp_rd_busy_2", {31'h0, rd_busy_2}, {31'h0, exp_busy(rd_addr_2)});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en_a  = 1'b0;
        wr_en_b  = 1'b0;
        busy_set = 1'b0;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 5));
    endfunction

    initial begin
        rst_n = 1'b0;
        rd_addr_1 = '0; rd_addr_2 = '0;
        wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        busy_set = 1'b0; busy_addr = '0;
        step(); step();
        check("reset_hold_data", rd_data_1, 32'h0);
        rst_n = 1'b1;
        step();

        // Reset is asynchronous: data vanishes without a clock edge.
        wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'd123;
        step(); idle();
        rd_addr_1 = 5'd7;
        #1 check("pre_reset_reg7", rd_data_1, 32'd123);
        rst_n = 1'b0;
        #1 check("async_reset_reg7", rd_data_1, 32'h0);
        step();
        rst_n = 1'b1;
        wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'd31;
        step(); idle();
        rd_addr_1 = 5'd7; rd_addr_2 = 5'd12;
        #1 check("basic_reg7", rd_data_1, 32'd31);
        check("basic_reg12", rd_data_2, 32'h0);

        // Dual write, then same-address collision.
        wr_en_a = 1'b1; wr_addr_a = 5'd2; wr_data_a = 32'd8;
        wr_en_b = 1'b1; wr_addr_b = 5'd5; wr_data_b = 32'hDEADBEEF;
        step();
        wr_addr_a = 5'd9; wr_data_a = 32'd1;
        wr_addr_b = 5'd9; wr_data_b = 32'd2;
        step(); idle();
        rd_addr_1 = 5'd2; rd_addr_2 = 5'd5;
        #1 check("dual_reg2", rd_data_1, 32'd8);
        check("dual_reg5", rd_data_2, 32'hDEADBEEF);
        rd_addr_1 = 5'd9; rd_addr_2 = 5'd9;
        #1 check("collide_reg9_p1", rd_data_1, 32'd2);
        check("collide_reg9_p2", rd_data_2, 32'd2);

        // Bypass priority.
        wr_en_a = 1'b1; wr_addr_a = 5'd4; wr_data_a = 32'd10;
        step(); idle();
        rd_addr_1 = 5'd4;
        #1 check("bypass_stored", rd_data_1, 32'd10);
        wr_en_a = 1'b1; wr_data_a = 32'd55;
        #1 check("bypass_a", rd_data_1, 32'd55);
        wr_en_b = 1'b1; wr_addr_b = 5'd4; wr_data_b = 32'd66;
        #1 check("bypass_b", rd_data_1, 32'd66);
        step(); idle();
        #1 check("bypass_b_stored", rd_data_1, 32'd66);

        // Zero register ignores writes and busy.
        wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hFFFFFFFF;
        busy_set = 1'b1; busy_addr = 5'd0;
        rd_addr_1 = 5'd0; rd_addr_2 = 5'd0;
        #1 check("zero_bypass", rd_data_1, 32'h0);
        check("zero_busy_now", {31'h0, rd_busy_2}, 32'h0);
        step(); idle();
        #1 check("zero_after", rd_data_2, 32'h0);
        check("zero_busy_after", {31'h0, rd_busy_1}, 32'h0);

        // Scoreboard set, same-cycle clear visibility, set-wins.
        busy_set = 1'b1; busy_addr = 5'd3;
        step(); idle();
        rd_addr_1 = 5'd3;
        #1 check("sb_busy", {31'h0, rd_busy_1}, 32'h1);
        wr_en_b = 1'b1; wr_addr_b = 5'd3; wr_data_b = 32'd77;
        busy_set = 1'b1; busy_addr = 5'd3;
        #1 check("sb_clear_busy", {31'h0, rd_busy_1}, 32'h0);
        check("sb_clear_data", rd_data_1, 32'd77);
        step(); idle();
        #1 check("sb_set_wins", {31'h0, rd_busy_1}, 32'h1);
        check("sb_reg3", rd_data_1, 32'd77);
        wr_en_b = 1'b1; wr_addr_b = 5'd3; wr_data_b = 32'd5;
        step(); idle();
        #1 check("sb_cleared", {31'h0, rd_busy_1}, 32'h0);

        // Reset during an outstanding load.
        busy_set = 1'b1; busy_addr = 5'd6;
        wr_en_a = 1'b1; wr_addr_a = 5'd6; wr_data_a = 32'd99;
        step(); idle();
        rd_addr_2 = 5'd6;
        #1 check("load_busy6", {31'h0, rd_busy_2}, 32'h1);
        rst_n = 1'b0;
        #1 check("reset_busy6", {31'h0, rd_busy_2}, 32'h0);
        check("reset_reg6", rd_data_2, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            rd_addr_1 = rnd_addr();
            rd_addr_2 = rnd_addr();
            wr_en_a   = $urandom_range(0, 1) == 1;
            wr_addr_a = rnd_addr();
            wr_data_a = $urandom;
            wr_en_b   = $urandom_range(0, 2) == 0;
            wr_addr_b = rnd_addr();
            wr_data_b = $urandom;
            busy_set  = $urandom_range(0, 2) == 0;
            busy_addr = rnd_addr();
            step();
        end

        rst_n = 1'b1;
        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
